// File: rtl/flag_branch_ctrl.sv
// Flag capture, PC/branch evaluation and run/halt sequencing for the core.
// Consumes ALU compare flags and drives the fetch PC.
module flag_branch_ctrl #(
    parameter int          PC_W   = 10,
    parameter int          OFF_W  = 8,
    parameter logic [2:0]  SEQ_OP = 3'd5,
    parameter logic [2:0]  SLT_OP = 3'd6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic [2:0]       alu_op,
    input  logic             flag_valid,
    input  logic             equalFlag,
    input  logic             lessThanFlag,
    input  logic [1:0]       br_type,
    input  logic [OFF_W-1:0] br_offset,
    output logic [PC_W-1:0]  pc,
    output logic             eq_q,
    output logic             lt_q,
    output logic             taken,
    output logic             running,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] BR_EQ  = 2'b01;
    localparam logic [1:0] BR_LT  = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            eq_d, lt_d;
    logic            taken_q, taken_d;
    logic            cond;
    logic [PC_W-1:0] off_sext;

    assign off_sext = PC_W'($signed(br_offset));

    // Branch condition always reads the registered flags, so a capture in the
    // same cycle only becomes visible to the next branch.
    assign cond = ((br_type == BR_EQ) && eq_q) ||
                  ((br_type == BR_LT) && lt_q) ||
                   (br_type == BR_JMP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        taken_d = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    pc_d    = cond ? (pc_q + off_sext) : (pc_q + PC_W'(1));
                    taken_d = cond;
                    if (flag_valid && (alu_op == SEQ_OP)) eq_d = equalFlag;
                    if (flag_valid && (alu_op == SLT_OP)) lt_d = lessThanFlag;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            taken_q <= taken_d;
        end
    end

    assign pc      = pc_q;
    assign taken   = taken_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_HALT);

endmodule

// File: doc/flag_branch_ctrl.md
Name: flag_branch_ctrl

Overview:
Control-side consumer of the ALU's compare results.
- Captures equalFlag/lessThanFlag into architectural flag registers when a seqOP/sltOP completes.
- Owns the program counter and evaluates beq/blt/jmp against the registered flags.
- Sequences run/halt of the core via a 3-state FSM.
- Sits between the ALU (flag producer) and instruction fetch (PC consumer).

Parameters:
- PC_W, 10, program counter width in bits; PC wraps modulo 2^PC_W.
- OFF_W, 8, branch offset width; offset is two's-complement, sign-extended to PC_W.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  synchronous active-low reset
- start  input  1  begin execution from PC 0 (IDLE or HALT only)
- halt  input  1  stop execution (RUN only)
- stall  input  1  freeze PC and flag capture this cycle
- alu_op  input  3  ALU opcode of the instruction completing this cycle (definitions encoding)
- flag_valid  input  1  ALU compare result valid this cycle
- equalFlag  input  1  ALU equal flag
- lessThanFlag  input  1  ALU less-than flag
- br_type  input  2  00 none, 01 beq, 10 blt, 11 jmp (unconditional)
- br_offset  input  OFF_W  signed PC-relative branch offset
- pc  output  PC_W  current program counter
- eq_q  output  1  registered equal flag
- lt_q  output  1  registered less-than flag
- taken  output  1  one-cycle pulse: last PC update was a taken branch/jump
- running  output  1  high in RUN
- done  output  1  high in HALT

Behaviour:
- Reset (RST_N=0 at rising edge): state=IDLE, pc=0, eq_q=0, lt_q=0, taken=0, running=0, done=0. Reset takes effect in any state, including mid-run; it overrides every other input.
- State IDLE:
  - start=1 → RUN; pc=0, eq_q=lt_q=0.
  - halt, stall, br_type and flag inputs are ignored.
- State RUN (running=1):
  - halt=1 → HALT next cycle; pc and flags hold, taken=0. halt has priority over stall and branch.
  - else stall=1: pc, eq_q, lt_q hold; taken=0.
  - else PC update:
    - cond = (br_type==01 & eq_q) | (br_type==10 & lt_q) | (br_type==11).
    - cond=1 → pc_next = pc + sext(br_offset); taken=1.
    - cond=0 → pc_next = pc + 1; taken=0.
    - All PC arithmetic is modulo 2^PC_W; wrap in both directions, no saturation.
  - Flag capture (same non-stalled, non-halted cycle):
    - flag_valid=1 & alu_op==seqOP → eq_q <= equalFlag.
    - flag_valid=1 & alu_op==sltOP → lt_q <= lessThanFlag.
    - Any other alu_op or flag_valid=0 leaves both flags unchanged.
  - Branch evaluation uses the pre-update flags when capture and branch coincide. New flags become visible to a branch one cycle later.
  - start is ignored in RUN.
- State HALT (done=1, running=0):
  - pc and flags hold.
  - start=1 → RUN with pc=0 and flags cleared.
- Output timing:
  - taken is registered and high for exactly one cycle per taken update.
  - All outputs are registered; zero combinational paths from inputs to outputs.
- Latency: one cycle from a branch decision to the new pc value. One cycle from flag_valid to eq_q/lt_q.

Test Plan:
- Reset mid-run: run 5 cycles (pc=5), drop RST_N for 1 cycle → pc=0, eq_q=lt_q=0, state IDLE, running=0, done=0.
- Sequential fetch: start, br_type=00 for 4 cycles → pc 0,1,2,3,4; taken stays 0.
- beq taken then not taken:
  - seqOP with flag_valid=1, equalFlag=1 at pc=2 → eq_q=1 next cycle.
  - Then br_type=01, br_offset=0xFD (−3) at pc=3 → pc=0, taken pulses 1.
  - Repeat with eq_q=0 → pc=4, taken=0.
- Same-cycle capture and branch: eq_q=0, sltOP/seqOP capture of 1 coincident with beq → not taken (old flag used); beq on the next cycle → taken.
- Wrap-around:
  - pc=1022, br_type=00 → 1023, then 0.
  - pc=1, jmp offset=0xFE (−2) → pc=1023.
- Stall/halt priority:
  - stall=1 with jmp and seqOP valid → pc, eq_q unchanged.
  - halt=1 with stall=1 and jmp → HALT, done=1, pc unchanged.
  - start in HALT → RUN, pc=0.
